// File: rtl/rc_pulse_offset_decoder_pkg.sv
// Shared definitions for the RC servo-PWM channel decoders: FSM encoding,
// default pulse limits and the width-to-range helper.
package rc_pulse_offset_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RISE = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_CONVERT   = 3'd3,
    ST_UPDATE    = 3'd4
  } state_t;

  localparam int unsigned DEF_CLK_HZ          = 50_000_000;
  localparam logic [15:0] DEF_PULSE_MIN_US    = 16'd1000;
  localparam logic [15:0] DEF_PULSE_MAX_US    = 16'd2000;
  localparam logic [15:0] DEF_GLITCH_US       = 16'd800;
  localparam logic [15:0] DEF_INVALID_US      = 16'd2500;
  localparam logic [15:0] DEF_TIMEOUT_US      = 16'd25000;
  localparam logic [7:0]  DEF_OFFSET_MAX      = 8'd50;
  localparam logic [7:0]  DEF_FAILSAFE_OFFSET = 8'd0;

  // Width clamped into [lo, hi] and re-based to lo.
  function automatic logic [15:0] clamp_sub(input logic [15:0] w,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
    if (w < lo) return 16'd0;
    if (w > hi) return hi - lo;
    return w - lo;
  endfunction

endpackage

// File: rtl/rc_pulse_offset_decoder_us_tick.sv
// Free-running microsecond prescaler: one-clock tick every CLK_HZ/1e6 clocks.
module rc_pulse_offset_decoder_us_tick #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned DIV   = CLK_HZ / 1_000_000;
  localparam int          CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (tick) cnt_q <= RELOAD;
    else           cnt_q <= cnt_q - CNT_W'(1);
  end

endmodule

// File: rtl/rc_pulse_offset_decoder.sv
// One RC servo-PWM channel: measures the high pulse in microseconds and converts
// it to a 0..OFFSET_MAX offset, with glitch/overlength rejection and loss failsafe.
//   state     | meaning
//   IDLE      | wait for settled, low line (never start mid-pulse)
//   WAIT_RISE | armed, waiting for rising edge
//   MEASURE   | line high, width_us counting
//   CONVERT   | repeated subtraction of STEP from clamped width
//   UPDATE    | publish quotient as new offset
module rc_pulse_offset_decoder
  import rc_pulse_offset_decoder_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
  parameter logic [15:0] PULSE_MIN_US    = DEF_PULSE_MIN_US,
  parameter logic [15:0] PULSE_MAX_US    = DEF_PULSE_MAX_US,
  parameter logic [7:0]  OFFSET_MAX      = DEF_OFFSET_MAX,
  parameter logic [15:0] GLITCH_US       = DEF_GLITCH_US,
  parameter logic [15:0] INVALID_US      = DEF_INVALID_US,
  parameter logic [15:0] TIMEOUT_US      = DEF_TIMEOUT_US,
  parameter logic [7:0]  FAILSAFE_OFFSET = DEF_FAILSAFE_OFFSET
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rc_pwm,
  output logic [7:0] offset,
  output logic       offset_valid,
  output logic       signal_lost
);
  localparam logic [15:0] STEP = (PULSE_MAX_US - PULSE_MIN_US) / {8'd0, OFFSET_MAX};

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [1:0]  sync_vld_q;
  logic [15:0] width_us_q, width_us_d;
  logic [15:0] to_us_q, to_us_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  quo_q, quo_d;
  logic [7:0]  offset_q, offset_d;
  logic        valid_q, valid_d;
  logic        lost_q, lost_d;
  logic        tick, rise, fall, sync_ok, timeout;

  rc_pulse_offset_decoder_us_tick #(.CLK_HZ(CLK_HZ)) u_us_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rise    = sync2_q & ~prev_q;
  assign fall    = ~sync2_q & prev_q;
  // sync2_q only reflects the pin once the reset-cleared pipeline has refilled
  assign sync_ok = sync_vld_q[1];
  // Loss is taken on the tick that carries to_us onto TIMEOUT_US, so IDLE can
  // rearm while the channel is still flagged lost.
  assign timeout = !rise && tick && (to_us_q == TIMEOUT_US - 16'd1);

  always_comb begin
    width_us_d = width_us_q;
    to_us_d    = to_us_q;
    if (rise) begin
      width_us_d = {15'd0, tick};
      to_us_d    = {15'd0, tick};
    end else begin
      if (sync2_q && tick && width_us_q != 16'hFFFF) width_us_d = width_us_q + 16'd1;
      if (tick && to_us_q != 16'hFFFF)               to_us_d    = to_us_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (sync_ok && !sync2_q) state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: if (rise) state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (fall)
          state_d = (width_us_q < GLITCH_US || width_us_q > INVALID_US) ? ST_WAIT_RISE : ST_CONVERT;
        else if (width_us_q > INVALID_US)
          state_d = ST_IDLE;
      end
      ST_CONVERT:   if (rem_q < STEP) state_d = ST_UPDATE;
      ST_UPDATE:    state_d = sync2_q ? ST_IDLE : ST_WAIT_RISE;
      default:      state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;
  end

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    offset_d = offset_q;
    valid_d  = 1'b0;
    lost_d   = lost_q;
    case (state_q)
      ST_MEASURE: if (fall) begin
        rem_d = clamp_sub(width_us_q, PULSE_MIN_US, PULSE_MAX_US);
        quo_d = 8'd0;
      end
      ST_CONVERT: if (rem_q >= STEP) begin
        rem_d = rem_q - STEP;
        quo_d = quo_q + 8'd1;
      end
      ST_UPDATE: begin
        offset_d = quo_q;
        valid_d  = 1'b1;
        lost_d   = 1'b0;
      end
      default: ;
    endcase
    if (timeout) begin
      offset_d = FAILSAFE_OFFSET;
      valid_d  = 1'b0;
      lost_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      sync_vld_q <= 2'b00;
      width_us_q <= 16'd0;
      to_us_q    <= 16'd0;
      rem_q      <= 16'd0;
      quo_q      <= 8'd0;
      offset_q   <= FAILSAFE_OFFSET;
      valid_q    <= 1'b0;
      lost_q     <= 1'b1;
    end else begin
      sync1_q    <= rc_pwm;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      width_us_q <= width_us_d;
      to_us_q    <= to_us_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      offset_q   <= offset_d;
      valid_q    <= valid_d;
      lost_q     <= lost_d;
    end
  end

  assign offset       = offset_q;
  assign offset_valid = valid_q;
  assign signal_lost  = lost_q;

endmodule

// File: tb/tb_rc_pulse_offset_decoder.sv
// Directed bench for rc_pulse_offset_decoder with a width-to-offset reference
// model and a per-cycle output checker.
module tb_rc_pulse_offset_decoder;

  localparam int TICK     = 2;          // clocks per microsecond at CLK_HZ = 2 MHz
  localparam int P_MIN    = 1000;
  localparam int P_MAX    = 2000;
  localparam int OMAX     = 50;
  localparam int GLITCH   = 800;
  localparam int INVALID  = 2500;
  localparam int TIMEOUT  = 4000;
  localparam int FAILSAFE = 0;
  localparam int LAT_MAX  = OMAX + 6;   // 2 sync + OMAX+3 + one posedge of observation slack
  localparam int GAP      = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rc_pwm = 1'b0;
  logic [7:0] offset;
  logic       offset_valid;
  logic       signal_lost;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int model_last = FAILSAFE;
  bit chk_en = 1'b0;
  int exp_q[$];

  rc_pulse_offset_decoder #(
    .CLK_HZ     (2_000_000),
    .TIMEOUT_US (16'(TIMEOUT))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rc_pwm       (rc_pwm),
    .offset       (offset),
    .offset_valid (offset_valid),
    .signal_lost  (signal_lost)
  );

  always #5 clk = ~clk;

  function automatic int model_offset(input int w);
    int c;
    c = (w < P_MIN) ? P_MIN : ((w > P_MAX) ? P_MAX : w);
    return ((c - P_MIN) * OMAX) / (P_MAX - P_MIN);
  endfunction

  // Outputs checked every cycle against the model's queue of expected updates.
  always @(negedge clk) begin
    if (chk_en) begin
      if (offset_valid) begin
        valid_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_valid: offset=%0d, no update expected", offset);
        end else begin
          model_last = exp_q.pop_front();
          if (offset !== 8'(model_last)) begin
            fails++;
            $display("FAIL update_value: offset=%0d expected=%0d", offset, model_last);
          end
        end
        tests++;
        if (signal_lost !== 1'b0) begin
          fails++;
          $display("FAIL lost_on_update: signal_lost=%b expected=0", signal_lost);
        end
      end else begin
        tests++;
        if (signal_lost === 1'b1 && offset !== 8'(FAILSAFE)) begin
          fails++;
          $display("FAIL failsafe_hold: offset=%0d expected=%0d", offset, FAILSAFE);
        end else if (signal_lost === 1'b0 && offset !== 8'(model_last)) begin
          fails++;
          $display("FAIL offset_hold: offset=%0d expected=%0d", offset, model_last);
        end else if (signal_lost !== 1'b0 && signal_lost !== 1'b1) begin
          fails++;
          $display("FAIL lost_known: signal_lost=%b", signal_lost);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int w_us);
    int v0;
    int n;
    bit upd;
    upd = (w_us >= GLITCH) && (w_us <= INVALID);
    v0  = valid_cnt;
    if (upd) exp_q.push_back(model_offset(w_us));
    rc_pwm = 1'b1;
    cycles(w_us * TICK);
    rc_pwm = 1'b0;
    if (upd) begin
      n = 0;
      while (valid_cnt == v0 && n < LAT_MAX) begin
        @(posedge clk);
        n++;
      end
      #1;
      tests++;
      if (valid_cnt == v0) begin
        fails++;
        $display("FAIL latency_w%0d: no offset_valid within %0d clk", w_us, LAT_MAX);
      end
    end
    cycles(GAP * TICK);
    chk($sformatf("valid_count_w%0d", w_us), valid_cnt - v0, upd ? 1 : 0);
  endtask

  initial begin
    int v0;
    rst = 1'b1;
    rc_pwm = 1'b0;
    cycles(4);
    rst = 1'b0;
    cycles(1);
    chk_en = 1'b1;
    chk("reset_offset", int'(offset), FAILSAFE);
    chk("reset_lost", int'(signal_lost), 1);
    chk("reset_valid", int'(offset_valid), 0);
    cycles(10);

    pulse(1500);
    chk("w1500_offset", int'(offset), 25);
    chk("w1500_lost", int'(signal_lost), 0);

    pulse(600);
    pulse(3000);
    chk("glitch_hold_offset", int'(offset), 25);

    pulse(900);
    pulse(2100);
    pulse(1020);
    chk("w1020_offset", int'(offset), 1);
    pulse(800);

    cycles(4500 * TICK);
    chk("timeout_lost", int'(signal_lost), 1);
    chk("timeout_offset", int'(offset), FAILSAFE);

    pulse(1200);
    chk("w1200_offset", int'(offset), 10);
    chk("w1200_lost", int'(signal_lost), 0);

    v0 = valid_cnt;
    rc_pwm = 1'b1;
    cycles(500 * TICK);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    chk("midrst_offset", int'(offset), FAILSAFE);
    chk("midrst_lost", int'(signal_lost), 1);
    chk("midrst_valid", int'(offset_valid), 0);
    cycles(1000 * TICK - 4);
    rc_pwm = 1'b0;
    cycles(GAP * TICK);
    chk("midrst_pulse_ignored", valid_cnt - v0, 0);

    pulse(1800);
    chk("w1800_offset", int'(offset), 40);

    pulse(1000);
    pulse(2000);
    pulse(1500);
    chk("frames_final_offset", int'(offset), 25);
    chk("pending_updates", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
